// File: rtl/am_shift_pkg.sv
// am_shift_pkg
//   Shared encodings for the iterative lane-aware shifter:
//   - shift-mode codes (SH_*),
//   - lane-size codes (LANE_*),
//   - FSM state type,
//   - lane_width() helper that maps a lane code to its width in bits.
package am_shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] LANE_4    = 2'b00;
  localparam logic [1:0] LANE_8    = 2'b01;
  localparam logic [1:0] LANE_FULL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Lane code 2'b11 is reserved and treated as full width.
  function automatic int unsigned lane_width(input logic [1:0] lane,
                                             input int unsigned width);
    case (lane)
      LANE_4:  return 32'd4;
      LANE_8:  return 32'd8;
      default: return width;
    endcase
  endfunction

endpackage

// File: rtl/am_lane_step.sv
// am_lane_step
//   Combinational single step of the shifter: shifts every lane of data_i
//   by k_i (0..STEP) positions without letting any bit cross a lane boundary.
//   Ports:
//     data_i  [WIDTH-1:0]  vector to shift
//     k_i     [KW-1:0]     positions to shift this step
//     mode_i  [1:0]        SH_LSL / SH_LSR / SH_ASR / SH_ROR
//     lane_i  [1:0]        LANE_4 / LANE_8 / LANE_FULL (11 = full)
//     data_o  [WIDTH-1:0]  shifted vector
module am_lane_step
  import am_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       lane_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] res4_s;
  logic [WIDTH-1:0] res8_s;
  logic [WIDTH-1:0] resf_s;

  // Bitwise lane-isolated shift; lw is a constant at each call site, so the
  // per-bit source selection folds down to a small mux per output bit.
  function automatic logic [WIDTH-1:0] shift_lanes(input logic [WIDTH-1:0] d,
                                                   input int k,
                                                   input logic [1:0] mode,
                                                   input int lw);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int pos;
      int base;
      pos  = i % lw;
      base = i - pos;
      case (mode)
        SH_LSL: begin
          if (pos >= k) r[i] = d[i-k];
          else          r[i] = 1'b0;
        end
        SH_LSR, SH_ASR: begin
          if (pos + k < lw)      r[i] = d[i+k];
          else if (mode == SH_ASR) r[i] = d[base+lw-1];
          else                   r[i] = 1'b0;
        end
        default: r[i] = d[base + ((pos + k) % lw)];
      endcase
    end
    return r;
  endfunction

  // One candidate result per lane size, selected by the registered lane code.
  always_comb begin
    res4_s = shift_lanes(data_i, int'(k_i), mode_i, 4);
    res8_s = shift_lanes(data_i, int'(k_i), mode_i, 8);
    resf_s = shift_lanes(data_i, int'(k_i), mode_i, WIDTH);
    case (lane_i)
      LANE_4:  data_o = res4_s;
      LANE_8:  data_o = res8_s;
      default: data_o = resf_s;
    endcase
  end

endmodule

// File: rtl/am_shifter_seq.sv
// am_shifter_seq
//   Iterative handshaked shifter. Accepts one operation in IDLE, shifts by up
//   to STEP positions per cycle in SHIFT, presents the result in DONE.
//   Ports:
//     clk, rst_n (sync active-low), flush (sync abort to IDLE)
//     in_valid/in_ready, in_data, in_amount, in_mode, in_lane  -- request
//     out_valid/out_ready, out_data                            -- result
//     busy  -- high while an operation is in SHIFT or DONE
module am_shifter_seq
  import am_shift_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STEP     = 1,
  localparam int SHAMT_W = $clog2(WIDTH) + 1,
  localparam int KW      = $clog2(STEP + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic [1:0]         in_mode,
  input  logic [1:0]         in_lane,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         lane_q, lane_d;
  logic               in_ready_q, out_valid_q, busy_q;

  logic [SHAMT_W-1:0] eff_s;
  logic [KW-1:0]      k_s;
  logic [WIDTH-1:0]   step_s;

  am_lane_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i (data_q),
    .k_i    (k_s),
    .mode_i (mode_q),
    .lane_i (lane_q),
    .data_o (step_s)
  );

  // Effective amount: rotates wrap modulo the lane width, other modes clamp to it.
  always_comb begin
    int unsigned lw;
    int unsigned amt;
    int unsigned e;
    lw  = lane_width(in_lane, WIDTH);
    amt = 32'(in_amount);
    if (in_mode == SH_ROR) e = amt % lw;
    else if (amt > lw)     e = lw;
    else                   e = amt;
    eff_s = SHAMT_W'(e);
  end

  // Positions to shift this cycle: min(STEP, remaining).
  always_comb begin
    if (rem_q > SHAMT_W'(STEP)) k_s = KW'(STEP);
    else                        k_s = rem_q[KW-1:0];
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    lane_d     = lane_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = in_mode;
          lane_d = in_lane;
          rem_d  = eff_s;
          if (eff_s == '0) begin
            state_d    = ST_DONE;
            out_data_d = in_data;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d = step_s;
        rem_d  = rem_q - SHAMT_W'(k_s);
        if (rem_d == '0) begin
          state_d    = ST_DONE;
          out_data_d = step_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort discards the operation and leaves the last delivered result visible.
    if (flush) begin
      state_d    = ST_IDLE;
      out_data_d = out_data_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and registered handshake outputs; reset dominates flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      out_data_q  <= '0;
      rem_q       <= '0;
      mode_q      <= SH_LSL;
      lane_q      <= LANE_4;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      lane_q      <= lane_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_am_shifter_seq.sv
module tb_am_shifter_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready, sel;
  logic [15:0] in_data;
  logic [4:0]  in_amount;
  logic [1:0]  in_mode, in_lane;

  logic        iv1, iv4, ordy1, ordy4;
  logic        ir1, ir4, ov1, ov4, bz1, bz4;
  logic [15:0] od1, od4;
  logic        ir, ov, bz;
  logic [15:0] od;

  // sel = 0 drives the STEP=1 instance, sel = 1 the STEP=4 instance
  assign iv1   = in_valid & ~sel;
  assign iv4   = in_valid & sel;
  assign ordy1 = out_ready | sel;
  assign ordy4 = out_ready | ~sel;
  assign ir = sel ? ir4 : ir1;
  assign ov = sel ? ov4 : ov1;
  assign bz = sel ? bz4 : bz1;
  assign od = sel ? od4 : od1;

  am_shifter_seq #(.WIDTH(16), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode), .in_lane(in_lane),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .busy(bz1));

  am_shifter_seq #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv4), .in_ready(ir4),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode), .in_lane(in_lane),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .busy(bz4));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: per lane, integer arithmetic on the lane value
  function automatic logic [15:0] model(input logic [15:0] d, input int amt,
                                        input logic [1:0] mode, input logic [1:0] lane,
                                        output int eff);
    int L;
    logic [31:0] mask, v, r, res;
    L = (lane == 2'd0) ? 4 : (lane == 2'd1) ? 8 : 16;
    mask = (32'd1 << L) - 32'd1;
    eff = (mode == 2'd3) ? (amt % L) : ((amt < L) ? amt : L);
    res = 32'd0;
    for (int base = 0; base < 16; base += L) begin
      v = (32'(d) >> base) & mask;
      case (mode)
        2'd0: r = (v << eff) & mask;
        2'd1: r = v >> eff;
        2'd2: r = v[L-1] ? ((v >> eff) | (mask & ~(mask >> eff))) : (v >> eff);
        default: r = ((v >> eff) | (v << (L - eff))) & mask;
      endcase
      res = res | (r << base);
    end
    return res[15:0];
  endfunction

  // Issues one operation and reports result and accept-to-valid latency
  task automatic do_op(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m,
                       input logic [1:0] l, output logic [15:0] res, output int lat,
                       output bit to);
    int w;
    to = 1'b0; w = 0; lat = 0; res = 16'h0;
    while (!ir && w < 50) begin @(posedge clk); #1; w++; end
    if (!ir) begin to = 1'b1; return; end
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amount = a; in_mode = m; in_lane = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom); in_mode = 2'($urandom); in_lane = 2'($urandom);
    lat = 1;
    while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!ov) to = 1'b1;
    res = od;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    in_data = 16'h0; in_amount = 5'd0; in_mode = 2'd0; in_lane = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready sel=%0d got %b exp 1", s, ir); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid sel=%0d got %b exp 0", s, ov); end
      n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL reset_busy sel=%0d got %b exp 0", s, bz); end
      n_checks++; if (od !== 16'h0) begin n_fail++; $display("FAIL reset_out_data sel=%0d got %h exp 0000", s, od); end
    end
    sel = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] vd [7], ve [7], res;
    logic [4:0]  va [7];
    logic [1:0]  vm [7], vl [7];
    int          vlat [7];
    int lat; bit to;
    vd[0]=16'h8000; va[0]=5'd3;  vm[0]=2'd2; vl[0]=2'd2; ve[0]=16'hF000; vlat[0]=4;
    vd[1]=16'h8F70; va[1]=5'd1;  vm[1]=2'd2; vl[1]=2'd0; ve[1]=16'hCF30; vlat[1]=2;
    vd[2]=16'h81FF; va[2]=5'd1;  vm[2]=2'd0; vl[2]=2'd1; ve[2]=16'h02FE; vlat[2]=2;
    vd[3]=16'h0001; va[3]=5'd1;  vm[3]=2'd3; vl[3]=2'd2; ve[3]=16'h8000; vlat[3]=2;
    vd[4]=16'h1234; va[4]=5'd5;  vm[4]=2'd3; vl[4]=2'd0; ve[4]=16'h8192; vlat[4]=2;
    vd[5]=16'hFFFF; va[5]=5'd20; vm[5]=2'd1; vl[5]=2'd2; ve[5]=16'h0000; vlat[5]=17;
    vd[6]=16'hA5A5; va[6]=5'd0;  vm[6]=2'd0; vl[6]=2'd2; ve[6]=16'hA5A5; vlat[6]=1;
    sel = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(vd[i], va[i], vm[i], vl[i], res, lat, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL directed_timeout case=%0d got timeout exp result", i); end
      n_checks++; if (res !== ve[i]) begin n_fail++; $display("FAIL directed_data case=%0d got %h exp %h", i, res, ve[i]); end
      n_checks++; if (lat != vlat[i]) begin n_fail++; $display("FAIL directed_latency case=%0d got %0d exp %0d", i, lat, vlat[i]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] res; int lat; bit to;
    sel = 1'b1; out_ready = 1'b0;
    do_op(16'h0001, 5'd7, 2'd0, 2'd2, res, lat, to);
    n_checks++; if (to || res !== 16'h0080) begin n_fail++; $display("FAIL hold_data got %h exp 0080", res); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL hold_latency got %0d exp 3", lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov !== 1'b1 || od !== 16'h0080 || ir !== 1'b0 || bz !== 1'b1) begin
        n_fail++; $display("FAIL hold_stable cycle=%0d got ov=%b od=%h ir=%b bz=%b exp 1 0080 0 1", c, ov, od, ir, bz);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ov !== 1'b0 || od !== 16'h0080 || ir !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got ov=%b od=%h ir=%b exp 0 0080 1", ov, od, ir);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] d, res, exp_d; logic [4:0] a; logic [1:0] m, l;
    int e, lat, exp_lat, step; bit to;
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; step = s ? 4 : 1;
      for (int i = 0; i < 30; i++) begin
        d = 16'($urandom); a = 5'($urandom_range(0, 31));
        m = 2'($urandom); l = 2'($urandom);
        exp_d = model(d, int'(a), m, l, e);
        exp_lat = 1 + (e + step - 1) / step;
        do_op(d, a, m, l, res, lat, to);
        n_checks++;
        if (to || res !== exp_d) begin
          n_fail++; $display("FAIL random_data step=%0d d=%h a=%0d m=%0d l=%0d got %h exp %h", step, d, a, m, l, res, exp_d);
        end
        n_checks++;
        if (lat != exp_lat) begin
          n_fail++; $display("FAIL random_latency step=%0d a=%0d m=%0d l=%0d got %0d exp %0d", step, a, m, l, lat, exp_lat);
        end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_flush_reset();
    logic [15:0] res, exp_d; int lat, e; bit to, seen;
    sel = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    // flush during the third SHIFT cycle
    @(negedge clk); in_valid = 1'b1; in_data = 16'h1357; in_amount = 5'd10; in_mode = 2'd0; in_lane = 2'd2;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_checks++;
    if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle got ir=%b ov=%b bz=%b exp 1 0 0", ir, ov, bz);
    end
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin @(posedge clk); #1; if (ov) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid got out_valid seen exp none"); end
    // flush together with in_valid in IDLE must not accept
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_amount = 5'd3;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (ir !== 1'b1 || bz !== 1'b0) begin
      n_fail++; $display("FAIL flush_blocks_accept got ir=%b bz=%b exp 1 0", ir, bz);
    end
    // complete one op so out_data is non-zero, then reset mid-shift
    do_op(16'h0001, 5'd2, 2'd0, 2'd2, res, lat, to);
    n_checks++; if (to || res !== 16'h0004) begin n_fail++; $display("FAIL pre_reset_op got %h exp 0004", res); end
    @(posedge clk); #1;
    @(negedge clk); in_valid = 1'b1; in_data = 16'hBEEF; in_amount = 5'd8; in_mode = 2'd1; in_lane = 2'd2;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    n_checks++;
    if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0 || od !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_shift got ir=%b ov=%b bz=%b od=%h exp 1 0 0 0000", ir, ov, bz, od);
    end
    exp_d = model(16'hC3A5, 6, 2'd2, 2'd1, e);
    do_op(16'hC3A5, 5'd6, 2'd2, 2'd1, res, lat, to);
    n_checks++;
    if (to || res !== exp_d || lat != 1 + e) begin
      n_fail++; $display("FAIL post_reset_op got %h lat %0d exp %h lat %0d", res, lat, exp_d, 1 + e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
